// File: rtl/branch_predictor_pkg.sv
// Shared types, sizes and counter update rule for the fetch-side branch predictor.
// Optional feature macro: BP_GSHARE_EN (global-history XOR indexing of the counter table).
`ifndef XLEN
`define XLEN 32
`endif

package branch_predictor_pkg;

  localparam int unsigned XLEN        = `XLEN;
  localparam int unsigned BTB_ENTRIES = 32;
  localparam int unsigned BTB_IDX_W   = $clog2(BTB_ENTRIES);
  localparam int unsigned BHT_ENTRIES = 64;
  localparam int unsigned BHT_IDX_W   = $clog2(BHT_ENTRIES);
  localparam int unsigned TAG_W       = 8;
  localparam int unsigned GHR_W       = 6;
  localparam int unsigned TAG_LSB     = BTB_IDX_W + 2;
  localparam int unsigned TAG_MSB     = TAG_W + BTB_IDX_W + 1;

  typedef logic [1:0] bp_cnt_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } bp_btb_entry_t;

  localparam bp_cnt_t BP_STRONG_NT = 2'b00;
  localparam bp_cnt_t BP_WEAK_NT   = 2'b01;
  localparam bp_cnt_t BP_STRONG_T  = 2'b11;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic bp_cnt_t bp_cnt_next(input bp_cnt_t cnt, input logic taken);
    bp_cnt_t res;
    res = cnt;
    if (taken) begin
      if (cnt != BP_STRONG_T) res = cnt + 2'd1;
    end else begin
      if (cnt != BP_STRONG_NT) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer: two combinational read ports, two write ports (slot 1 wins).
module bp_btb
  import branch_predictor_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0][XLEN-1:0] rd_pc,
  output logic [1:0]           hit_c,
  output logic [1:0][XLEN-1:0] target_c,
  input  logic [1:0]           wr_en,
  input  logic [1:0][XLEN-1:0] wr_pc,
  input  logic [1:0][XLEN-1:0] wr_target
);

  bp_btb_entry_t entries [BTB_ENTRIES];

  logic [1:0][BTB_IDX_W-1:0] rd_idx;
  logic [1:0][BTB_IDX_W-1:0] wr_idx;
  logic [1:0][TAG_W-1:0]     rd_tag;
  logic [1:0][TAG_W-1:0]     wr_tag;

  // PC bits outside index/tag are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc[0][XLEN-1:TAG_MSB+1], rd_pc[0][1:0],
                            rd_pc[1][XLEN-1:TAG_MSB+1], rd_pc[1][1:0],
                            wr_pc[0][XLEN-1:TAG_MSB+1], wr_pc[0][1:0],
                            wr_pc[1][XLEN-1:TAG_MSB+1], wr_pc[1][1:0]};

  // Field extraction and tag compare for both read ports.
  always_comb begin
    rd_idx   = '0;
    wr_idx   = '0;
    rd_tag   = '0;
    wr_tag   = '0;
    hit_c    = '0;
    target_c = '0;
    for (int s = 0; s < 2; s++) begin
      rd_idx[s]   = rd_pc[s][BTB_IDX_W+1:2];
      rd_tag[s]   = rd_pc[s][TAG_MSB:TAG_LSB];
      wr_idx[s]   = wr_pc[s][BTB_IDX_W+1:2];
      wr_tag[s]   = wr_pc[s][TAG_MSB:TAG_LSB];
      hit_c[s]    = entries[rd_idx[s]].valid && (entries[rd_idx[s]].tag == rd_tag[s]);
      target_c[s] = entries[rd_idx[s]].target;
    end
  end

  // Entry storage; slot 1 is written last so it overrides slot 0 on an index clash.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) entries[i].valid <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (wr_en[s]) begin
          entries[wr_idx[s]] <= '{valid: 1'b1, tag: wr_tag[s], target: wr_target[s]};
        end
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Two-wide BTB + 2-bit counter branch predictor with combinational lookup and retire-time training.
// Optional feature macro: BP_GSHARE_EN (counter index XORed with a retire-updated global history).
module branch_predictor
  import branch_predictor_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           fetch_valid,
  input  logic [1:0][XLEN-1:0] fetch_pc,
  output logic [1:0]           pred_take,
  output logic [1:0][XLEN-1:0] pred_target,
  input  logic [1:0]           upd_valid,
  input  logic [1:0][XLEN-1:0] upd_pc,
  input  logic [1:0]           upd_taken,
  input  logic [1:0][XLEN-1:0] upd_target
);

  bp_cnt_t bht [BHT_ENTRIES];

  logic [1:0]                upd_en;
  logic [1:0][BHT_IDX_W-1:0] rd_bht_idx;
  logic [1:0][BHT_IDX_W-1:0] wr_bht_idx;
  logic [1:0]                btb_hit;
  logic [1:0][XLEN-1:0]      btb_target;
  bp_cnt_t                   cnt0_next;
  bp_cnt_t                   cnt1_old;
  bp_cnt_t                   cnt1_next;

  // Slot 1 only counts when slot 0 also retires.
  assign upd_en = {upd_valid[1] & upd_valid[0], upd_valid[0]};

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;
  logic [GHR_W-1:0] ghr_mid;
  logic [GHR_W-1:0] ghr_next;

  // History after slot 0's shift and after both shifts.
  always_comb begin
    ghr_mid  = upd_en[0] ? {ghr[GHR_W-2:0], upd_taken[0]} : ghr;
    ghr_next = upd_en[1] ? {ghr_mid[GHR_W-2:0], upd_taken[1]} : ghr_mid;
  end

  // Non-speculative global history register.
  always_ff @(posedge clock) begin
    if (reset) ghr <= '0;
    else       ghr <= ghr_next;
  end

  // Gshare indices: fetch uses current history, slot 1 update sees slot 0's shift.
  always_comb begin
    rd_bht_idx    = '0;
    rd_bht_idx[0] = fetch_pc[0][BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr);
    rd_bht_idx[1] = fetch_pc[1][BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr);
    wr_bht_idx    = '0;
    wr_bht_idx[0] = upd_pc[0][BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr);
    wr_bht_idx[1] = upd_pc[1][BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_mid);
  end
`else
  // Bimodal indices straight from the PC.
  always_comb begin
    rd_bht_idx    = '0;
    rd_bht_idx[0] = fetch_pc[0][BHT_IDX_W+1:2];
    rd_bht_idx[1] = fetch_pc[1][BHT_IDX_W+1:2];
    wr_bht_idx    = '0;
    wr_bht_idx[0] = upd_pc[0][BHT_IDX_W+1:2];
    wr_bht_idx[1] = upd_pc[1][BHT_IDX_W+1:2];
  end
`endif

  bp_btb u_btb (
    .clock     (clock),
    .reset     (reset),
    .rd_pc     (fetch_pc),
    .hit_c     (btb_hit),
    .target_c  (btb_target),
    .wr_en     (upd_en & upd_taken),
    .wr_pc     (upd_pc),
    .wr_target (upd_target)
  );

  // Counter next values; a same-index slot 1 update chains off slot 0's result.
  always_comb begin
    cnt0_next = bp_cnt_next(bht[wr_bht_idx[0]], upd_taken[0]);
    cnt1_old  = (upd_en[0] && (wr_bht_idx[1] == wr_bht_idx[0])) ? cnt0_next : bht[wr_bht_idx[1]];
    cnt1_next = bp_cnt_next(cnt1_old, upd_taken[1]);
  end

  // Counter table training at retire.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BP_WEAK_NT;
    end else begin
      if (upd_en[0]) bht[wr_bht_idx[0]] <= cnt0_next;
      if (upd_en[1]) bht[wr_bht_idx[1]] <= cnt1_next;
    end
  end

  // Zero-latency prediction from pre-update table contents.
  always_comb begin
    pred_take   = '0;
    pred_target = '0;
    for (int s = 0; s < 2; s++) begin
      pred_take[s]   = fetch_valid[s] & btb_hit[s] & bht[rd_bht_idx[s]][1];
      pred_target[s] = pred_take[s] ? btb_target[s] : fetch_pc[s] + XLEN'(4);
    end
  end

  // A younger retiring branch without the older one is a pipeline bug.
  slot1_needs_slot0: assert property (@(posedge clock) disable iff (reset)
                                      !(upd_valid[1] && !upd_valid[0]));

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: behavioural table model plus directed literal checks.
`ifndef XLEN
`define XLEN 32
`endif

module tb_branch_predictor;

  localparam int N_BTB = 32;
  localparam int N_BHT = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        fetch_valid;
  logic [1:0][31:0]  fetch_pc;
  logic [1:0]        pred_take;
  logic [1:0][31:0]  pred_target;
  logic [1:0]        upd_valid;
  logic [1:0][31:0]  upd_pc;
  logic [1:0]        upd_taken;
  logic [1:0][31:0]  upd_target;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  branch_predictor dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .pred_take   (pred_take),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  // ---------------- behavioural model ----------------
  int          m_cnt  [N_BHT];
  bit          m_bv   [N_BTB];
  logic [31:0] m_bpc  [N_BTB];
  logic [31:0] m_btgt [N_BTB];
  int          m_ghr;
  bit          started = 0;

  function automatic int bht_of(input logic [31:0] pc, input int hist);
    int i;
    i = int'((pc / 4) % N_BHT);
`ifdef BP_GSHARE_EN
    i = i ^ hist;
`endif
    return i;
  endfunction

  // Model state follows each retire sequentially, slot 0 then slot 1.
  always @(posedge clock) begin
    int bi;
    int ci;
    if (reset) begin
      for (int i = 0; i < N_BHT; i++) m_cnt[i] = 1;
      for (int i = 0; i < N_BTB; i++) m_bv[i] = 0;
      m_ghr   = 0;
      started = 1;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (upd_valid[s] && (s == 0 || upd_valid[0])) begin
          ci = bht_of(upd_pc[s], m_ghr);
          bi = int'((upd_pc[s] / 4) % N_BTB);
          if (upd_taken[s]) begin
            m_cnt[ci]  = (m_cnt[ci] == 3) ? 3 : m_cnt[ci] + 1;
            m_bv[bi]   = 1;
            m_bpc[bi]  = upd_pc[s];
            m_btgt[bi] = upd_target[s];
          end else begin
            m_cnt[ci] = (m_cnt[ci] == 0) ? 0 : m_cnt[ci] - 1;
          end
          m_ghr = (m_ghr * 2 + int'(upd_taken[s])) % 64;
        end
      end
    end
  end

  // Compare DUT predictions against the model every cycle.
  always @(negedge clock) begin
    int          bi;
    bit          hit;
    logic        exp_take;
    logic [31:0] exp_tgt;
    if (started && !reset) begin
      for (int s = 0; s < 2; s++) begin
        bi       = int'((fetch_pc[s] / 4) % N_BTB);
        hit      = m_bv[bi] && (((m_bpc[bi] >> 7) & 32'hFF) == ((fetch_pc[s] >> 7) & 32'hFF));
        exp_take = fetch_valid[s] && hit && (m_cnt[bht_of(fetch_pc[s], m_ghr)] >= 2);
        exp_tgt  = exp_take ? m_btgt[bi] : fetch_pc[s] + 32'd4;
        checks++;
        if (pred_take[s] !== exp_take || pred_target[s] !== exp_tgt) begin
          errors++;
          $display("FAIL model slot%0d pc=%h: got take=%b tgt=%h, expected take=%b tgt=%h",
                   s, fetch_pc[s], pred_take[s], pred_target[s], exp_take, exp_tgt);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_fetch(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    fetch_valid = v;
    fetch_pc[0] = p0;
    fetch_pc[1] = p1;
  endtask

  task automatic set_upd(input int s, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    upd_valid[s]  = 1'b1;
    upd_pc[s]     = pc;
    upd_taken[s]  = t;
    upd_target[s] = tgt;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    upd_valid = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic expect_pred(input string name, input logic [1:0] take,
                             input logic [31:0] t0, input logic [31:0] t1);
    @(negedge clock);
    checks++;
    if (pred_take !== take || pred_target[0] !== t0 || pred_target[1] !== t1) begin
      errors++;
      $display("FAIL %s: got take=%b tgt=%h,%h expected take=%b tgt=%h,%h",
               name, pred_take, pred_target[0], pred_target[1], take, t0, t1);
    end
  endtask

  logic [31:0] pool [8];

  initial begin
    pool = '{32'h200, 32'h204, 32'h280, 32'h600, 32'h240, 32'h1000, 32'h1004, 32'h300};
    reset      = 1'b1;
    upd_valid  = 2'b00;
    upd_pc     = '0;
    upd_taken  = 2'b00;
    upd_target = '0;
    set_fetch(2'b11, 32'h100, 32'h104);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    expect_pred("reset", 2'b00, 32'h104, 32'h108);

`ifndef BP_GSHARE_EN
    // Training 01 -> 10 -> 11, then back down.
    set_upd(0, 32'h200, 1'b1, 32'h400); step();
    set_fetch(2'b11, 32'h200, 32'h100);
    expect_pred("train_once", 2'b01, 32'h400, 32'h104);
    set_upd(0, 32'h200, 1'b1, 32'h400); step();
    expect_pred("train_twice", 2'b01, 32'h400, 32'h104);
    set_upd(0, 32'h200, 1'b0, 32'h0); step();
    expect_pred("untrain_once", 2'b01, 32'h400, 32'h104);
    set_upd(0, 32'h200, 1'b0, 32'h0); step();
    expect_pred("untrain_twice", 2'b00, 32'h204, 32'h104);

    // fetch_valid low suppresses a trained hit.
    set_upd(0, 32'h200, 1'b1, 32'h400); step();
    set_fetch(2'b00, 32'h200, 32'h100);
    expect_pred("fetch_invalid", 2'b00, 32'h204, 32'h104);

    // Reset discards training.
    set_fetch(2'b11, 32'h200, 32'h100);
    do_reset();
    expect_pred("mid_reset", 2'b00, 32'h204, 32'h104);

    // Same-cycle dual update to one entry: counter 01->11, younger target.
    set_upd(0, 32'h300, 1'b1, 32'h500);
    set_upd(1, 32'h300, 1'b1, 32'h600);
    step();
    set_fetch(2'b11, 32'h300, 32'h304);
    expect_pred("dual_same", 2'b01, 32'h600, 32'h308);
    set_upd(0, 32'h300, 1'b0, 32'h0); step();
    expect_pred("dual_saturated", 2'b01, 32'h600, 32'h308);

    // Aliasing on the BTB index with a different tag.
    do_reset();
    set_upd(0, 32'h200, 1'b1, 32'h400); step();
    set_upd(0, 32'h200, 1'b1, 32'h400); step();
    set_fetch(2'b11, 32'h280, 32'h200);
    expect_pred("alias_btb", 2'b10, 32'h284, 32'h400);
    set_fetch(2'b11, 32'h600, 32'h200);
    expect_pred("alias_tag", 2'b10, 32'h604, 32'h400);

    // Lookup in the update cycle sees pre-update state.
    step();
    set_upd(0, 32'h240, 1'b1, 32'h800);
    set_fetch(2'b11, 32'h240, 32'h600);
    expect_pred("no_bypass", 2'b00, 32'h244, 32'h604);
    step();
    expect_pred("after_update", 2'b01, 32'h800, 32'h604);

    // Two slots training distinct entries.
    set_upd(0, 32'h1000, 1'b1, 32'hA00);
    set_upd(1, 32'h1004, 1'b1, 32'hB00);
    step();
    set_fetch(2'b11, 32'h1000, 32'h1004);
    expect_pred("dual_distinct", 2'b11, 32'hA00, 32'hB00);
`else
    // One taken retire moves history to 1, so 0x200 now reads an untrained counter.
    set_upd(0, 32'h200, 1'b1, 32'h400); step();
    set_fetch(2'b11, 32'h200, 32'h100);
    expect_pred("gshare_history", 2'b00, 32'h204, 32'h104);
`endif

    // Mixed traffic checked by the model each cycle.
    for (int n = 0; n < 300; n++) begin
      int sel;
      set_fetch(2'($urandom_range(0, 3)), pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)]);
      sel = $urandom_range(0, 2);
      if (sel >= 1) set_upd(0, pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                            32'($urandom_range(0, 255)) << 2);
      if (sel == 2) set_upd(1, pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                            32'($urandom_range(0, 255)) << 2);
      step();
    end

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Two-wide fetch-side direction and target predictor: direct-mapped BTB plus a table of 2-bit saturating counters (BHT).
- Lookup is combinational from the two fetch PCs. Tables are trained at retire from resolved branch outcomes.
- Its prediction fields travel through the ROB and are compared against execute results by the retire-stage mispredict logic.

Parameters:
- BTB_ENTRIES, 32, BTB depth (power of 2); BTB_IDX_W = log2(BTB_ENTRIES)
- BHT_ENTRIES, 64, counter-table depth (power of 2); BHT_IDX_W = log2(BHT_ENTRIES)
- TAG_W, 8, BTB tag width
- GHR_W, 6, global history length (used only with BP_GSHARE_EN; must be <= BHT_IDX_W)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- fetch_valid  in  2  lookup request per fetch slot (slot 0 older)
- fetch_pc  in  2x`XLEN  PCs to predict
- pred_take  out  2  predicted taken
- pred_target  out  2x`XLEN  predicted next PC
- upd_valid  in  2  retiring branch per slot; slot 1 valid only when slot 0 also retires
- upd_pc  in  2x`XLEN  retiring branch PC
- upd_taken  in  2  resolved direction
- upd_target  in  2x`XLEN  resolved target

Behaviour:
- Index and tag fields:
  - BHT index = fetch_pc[BHT_IDX_W+1:2].
  - BTB index = fetch_pc[BTB_IDX_W+1:2].
  - BTB tag = fetch_pc[TAG_W+BTB_IDX_W+1:BTB_IDX_W+2].
- Lookup (zero latency, combinational):
  - hit = btb_valid[idx] && tag match.
  - pred_take = fetch_valid && hit && counter[1].
  - pred_target = pred_take ? btb_target : fetch_pc+4.
  - When fetch_valid=0: pred_take=0, pred_target=fetch_pc+4.
- Update (registered, visible the cycle after the upd_valid edge):
  - Counter: +1 on taken, saturating at 2'b11; -1 on not-taken, saturating at 2'b00.
  - BTB: written (valid=1, tag, target) only when upd_taken=1. Not-taken updates leave the BTB unchanged.
- Both update slots hitting the same BHT index: apply sequentially, final = f(f(old, taken0), taken1). Example: 2'b01 with T,T becomes 2'b11.
- Both update slots hitting the same BTB index and both taken: slot 1 (younger) wins.
- Update and lookup to the same entry in the same cycle: lookup returns the pre-update value; there is no bypass.
- upd_valid[1]=1 with upd_valid[0]=0 is illegal; assert in simulation, and RTL ignores slot 1.
- Reset: all BTB valid bits cleared (tags/targets don't-care), all counters 2'b01 (weakly not-taken), GHR cleared.
  - Reset mid-stream discards all training. Outputs are combinational, so on the cycle after reset they reflect the cleared tables (pred_take=0, pred_target=pc+4).

Optional Feature:
- BP_GSHARE_EN defined:
  - BHT index = fetch_pc[BHT_IDX_W+1:2] XOR {zero-extended GHR}.
  - GHR is a GHR_W-bit register updated at retire only, non-speculatively: shift in upd_taken[0] then upd_taken[1] for valid slots; 0, 1 or 2 shifts per cycle.
  - Both fetch slots use the current GHR. Updates index with the GHR value before this cycle's shifts for slot 0, and after slot 0's shift for slot 1.
- Not defined: pure bimodal PC indexing; no GHR register is instantiated.

Decomposition:
- Shared package:
  - BP_BTB_ENTRY struct {valid, tag[TAG_W], target[`XLEN]}
  - BP_CNT typedef logic[1:0]
  - constants BP_WEAK_NT=2'b01, BP_STRONG_T=2'b11
- Sub-module bp_btb: BTB storage, tag compare, two read ports, two write ports with slot-1 priority.
- Counter next-state function lives in the package so both update slots share it.

Test Plan:
- Reset, fetch_pc={0x100,0x104}, fetch_valid=2'b11 -> pred_take=2'b00, pred_target={0x104,0x108}.
- Retire slot0 pc=0x200 taken target 0x400, twice on separate cycles -> fetch 0x200 gives pred_take=1, pred_target=0x400. Counter goes 01→10→11.
- From counter 11 at 0x200: retire not-taken once -> still predicted taken (10). Retire not-taken again -> pred_take=0, pred_target=0x204.
- Same-cycle dual update to 0x300 (T, target 0x500) and 0x300 (T, target 0x600) from reset -> counter 11, pred_target=0x600.
- Aliasing: train 0x200 taken, then fetch pc 0x200+(BTB_ENTRIES*4) (same index, different tag) -> pred_take=0, pred_target=pc+4.
- BP_GSHARE_EN: train 0x200 taken under GHR=0, then retire unrelated not-taken/taken branches to make GHR≠0 -> 0x200 reads a different counter and pred_take=0. Same-cycle update/lookup returns the old value.
